// File: rtl/lhs_pack_writer.sv
// rtl/lhs_pack_writer.sv - byte-to-word packer with nibble-swap, word memory and emit counter
module lhs_pack_writer #(
   parameter int BYTE_W = 8,
   parameter int NBYTES = 2,
   parameter int DEPTH  = 4,
   localparam int W     = BYTE_W * NBYTES,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_swap,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_word,
   input  logic [AW-1:0]     rd_addr,
   output logic [W-1:0]      rd_data,
   output logic [7:0]        word_count
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int HW = BYTE_W / 2;

   typedef struct packed {
      logic [HW-1:0] hi;
      logic [HW-1:0] lo;
   } byte_t;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IW-1:0]  byte_idx;
   logic [AW-1:0]  wr_ptr;
   logic [W-1:0]   word;
   logic [W-1:0]   word_done;
   logic [7:0]     count_r;
   logic [W-1:0]   mem [DEPTH];
   byte_t          byte_in;
   logic           in_fire;
   logic           out_fire;
   logic           last_byte;

   assign last_byte  = (byte_idx == IW'(NBYTES - 1));
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign out_word   = word;
   assign word_count = count_r;
   assign rd_data    = mem[rd_addr];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs; a byte offered during HOLD is never taken
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && last_byte) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // Shape the incoming byte into its {hi,lo} halves, exchanging them on swap
   always_comb begin
      byte_in = '0;
      if (in_swap) {byte_in.lo, byte_in.hi} = in_data;
      else         {byte_in.hi, byte_in.lo} = in_data;
   end

   // Word as it will look after this byte lands; used for the memory copy
   always_comb begin
      word_done = word;
      word_done[byte_idx*BYTE_W +: BYTE_W] = byte_in;
   end

   // Packing datapath: byte slot write, index/pointer advance, emit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx <= '0;
         wr_ptr   <= '0;
         word     <= '0;
         count_r  <= '0;
      end else begin
         if (in_fire) begin
            word[byte_idx*BYTE_W +: BYTE_W] <= byte_in;
            if (last_byte) begin
               byte_idx <= '0;
               wr_ptr   <= wr_ptr + 1'b1;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
         if (out_fire) count_r <= count_r + 8'd1;
      end
   end

   // Word memory: completed word stored on the final byte, no reset on contents
   always_ff @(posedge clk) begin
      if (in_fire && last_byte) mem[wr_ptr] <= word_done;
   end

endmodule

// File: tb/tb_lhs_pack_writer.sv
// tb/tb_lhs_pack_writer.sv - scoreboard bench for lhs_pack_writer
module tb_lhs_pack_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        in_swap = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_word;
   logic [1:0]  rd_addr = '0;
   logic [15:0] rd_data;
   logic [7:0]  word_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];
   logic [15:0] model_mem [4];
   logic [1:0]  model_ptr = '0;
   logic [7:0]  model_count = '0;

   lhs_pack_writer #(.BYTE_W(8), .NBYTES(2), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_swap(in_swap),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .rd_addr(rd_addr), .rd_data(rd_data), .word_count(word_count)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   function automatic logic [7:0] shape(input logic [7:0] d, input logic s);
      return s ? {d[3:0], d[7:4]} : d;
   endfunction

   task automatic push_exp(input logic [7:0] b0, input logic s0, input logic [7:0] b1, input logic s1);
      logic [15:0] w;
      w = {shape(b1, s1), shape(b0, s0)};
      exp_q.push_back(w);
      model_mem[model_ptr] = w;
      model_ptr = model_ptr + 2'd1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      exp_q.delete(); model_ptr = '0; model_count = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s);
      int n;
      in_data = d; in_swap = s; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_byte_timeout in_ready=%b required=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic recv_word(input string name);
      int n;
      logic [15:0] e;
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout out_valid=%b required=1", name, out_valid);
      end else if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s_unexpected out_word=%h required=none", name, out_word);
      end else begin
         e = exp_q.pop_front();
         if (out_word !== e) begin
            errors++;
            $display("FAIL %s out_word=%h required=%h", name, out_word, e);
         end
         @(posedge clk); #1;
         model_count = model_count + 8'd1;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_hs in_ready,out_valid=%b required=10", {in_ready, out_valid});
      end
      checks++;
      if (out_word !== 16'h0000) begin
         errors++;
         $display("FAIL reset_word out_word=%h required=0000", out_word);
      end
      checks++;
      if (word_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_count word_count=%0d required=0", word_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      push_exp(8'h34, 1'b0, 8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency out_valid=%b required=1", out_valid);
      end
      recv_word("basic_word");
      rd_addr = 2'd0; #1;
      checks++;
      if (rd_data !== model_mem[0]) begin
         errors++;
         $display("FAIL basic_mem rd_data=%h required=%h", rd_data, model_mem[0]);
      end
      checks++;
      if (word_count !== model_count) begin
         errors++;
         $display("FAIL basic_count word_count=%0d required=%0d", word_count, model_count);
      end
   endtask

   task automatic test_swap();
      push_exp(8'hAB, 1'b1, 8'hCD, 1'b0);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b0);
      recv_word("swap_word");
   endtask

   task automatic test_backpressure();
      logic [15:0] e;
      out_ready = 1'b0;
      push_exp(8'h78, 1'b0, 8'h56, 1'b0);
      send_byte(8'h78, 1'b0);
      send_byte(8'h56, 1'b0);
      in_valid = 1'b1; in_data = 8'h99; in_swap = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({in_ready, out_valid} !== 2'b01 || out_word !== 16'h5678) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d in_ready,out_valid=%b out_word=%h required=01 5678",
                     i, {in_ready, out_valid}, out_word);
         end
      end
      out_ready = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if (out_word !== e) begin
         errors++;
         $display("FAIL bp_word out_word=%h required=%h", out_word, e);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      model_count = model_count + 8'd1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10 || out_word !== 16'h5678) begin
         errors++;
         $display("FAIL bp_after in_ready,out_valid=%b out_word=%h required=10 5678",
                  {in_ready, out_valid}, out_word);
      end
      push_exp(8'h99, 1'b0, 8'h11, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (out_word !== 16'h5699) begin
         errors++;
         $display("FAIL bp_next_byte out_word=%h required=5699", out_word);
      end
      in_data = 8'h11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      recv_word("bp_follow");
   endtask

   task automatic test_wrap();
      logic [7:0] b;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         b = {k[3:0], k[3:0]};
         push_exp(b, 1'b0, b, 1'b0);
         send_byte(b, 1'b0);
         send_byte(b, 1'b0);
         recv_word("wrap_word");
      end
      push_exp(8'h55, 1'b0, 8'h55, 1'b0);
      send_byte(8'h55, 1'b0);
      rd_addr = 2'd0; #1;
      checks++;
      if (rd_data !== 16'h1111) begin
         errors++;
         $display("FAIL wrap_old rd_data=%h required=1111", rd_data);
      end
      send_byte(8'h55, 1'b0);
      recv_word("wrap_word5");
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0]; #1;
         checks++;
         if (rd_data !== model_mem[a]) begin
            errors++;
            $display("FAIL wrap_mem addr=%0d rd_data=%h required=%h", a, rd_data, model_mem[a]);
         end
      end
      checks++;
      if (word_count !== model_count) begin
         errors++;
         $display("FAIL wrap_count word_count=%0d required=%0d", word_count, model_count);
      end
   endtask

   task automatic test_reset_midword();
      send_byte(8'h77, 1'b0);
      #2;
      rst_n = 1'b0;
      exp_q.delete(); model_ptr = '0; model_count = '0;
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10 || out_word !== 16'h0000 || word_count !== 8'd0) begin
         errors++;
         $display("FAIL midrst_async in_ready,out_valid=%b out_word=%h count=%0d required=10 0000 0",
                  {in_ready, out_valid}, out_word, word_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_exp(8'h01, 1'b0, 8'h02, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      recv_word("midrst_word");
      rd_addr = 2'd0; #1;
      checks++;
      if (rd_data !== 16'h0201) begin
         errors++;
         $display("FAIL midrst_mem rd_data=%h required=0201", rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_swap();
      test_backpressure();
      test_wrap();
      test_reset_midword();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
